// File: rtl/pin_entry_pkg.sv
// rtl/pin_entry_pkg.sv - key codes, FSM states and defaults for the PIN entry keypad
package pin_entry_pkg;

  localparam int DEFAULT_DIGITS = 4;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RESP,
    S_HOLD
  } pin_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_entry_keypad_digit_buffer.sv
// rtl/pin_entry_keypad_digit_buffer.sv - append/backspace/clear register holding the BCD PIN and its digit count
module pin_digit_buffer
  import pin_entry_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  bksp_i,
  input  logic                  clear_i,
  input  logic [3:0]            digit_i,
  output logic [4*DIGITS-1:0]   pin_o,
  output logic [2:0]            count_o
);

  logic [4*DIGITS-1:0] pin_q, pin_d;
  logic [2:0]          count_q, count_d;

  // Clear wins over everything; a full buffer silently drops extra digits.
  always_comb begin
    pin_d   = pin_q;
    count_d = count_q;
    if (clear_i) begin
      pin_d   = '0;
      count_d = '0;
    end else if (push_i && (count_q < 3'(DIGITS))) begin
      pin_d   = {pin_q[4*DIGITS-5:0], digit_i};
      count_d = count_q + 3'd1;
    end else if (bksp_i && (count_q != 3'd0)) begin
      pin_d   = pin_q >> 4;
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pin_q   <= '0;
      count_q <= '0;
    end else begin
      pin_q   <= pin_d;
      count_q <= count_d;
    end
  end

  assign pin_o   = pin_q;
  assign count_o = count_q;

endmodule

// File: rtl/pin_entry_keypad.sv
// rtl/pin_entry_keypad.sv - keypad PIN collector that sends the PIN word and tracks grant/deny/timeout/lockout
module pin_entry_keypad
  import pin_entry_pkg::*;
#(
  parameter int DIGITS       = DEFAULT_DIGITS,
  parameter int RESP_TIMEOUT = 16,
  parameter int DENY_HOLD    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  access_granted,
  input  logic                  access_denied,
  output logic [4*DIGITS-1:0]   pin_out,
  output logic                  pin_valid,
  output logic [2:0]            digit_count,
  output logic                  busy,
  output logic                  unlock_pulse,
  output logic                  fail_pulse,
  output logic                  entry_error
);

  localparam int CNT_MAX = (RESP_TIMEOUT > DENY_HOLD) ? RESP_TIMEOUT : DENY_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  pin_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [4*DIGITS-1:0] pin_out_q;
  logic                pin_valid_q, unlock_q, fail_q, error_q;

  logic                key_fire, buf_push, buf_bksp, buf_clear, full;
  logic [4*DIGITS-1:0] buf_pin;

  // Keys only reach the buffer in IDLE; anything pressed while busy is lost.
  assign key_fire  = key_valid && (state_q == S_IDLE);
  assign buf_push  = key_fire && is_digit(key_code);
  assign buf_bksp  = key_fire && (key_code == KEY_BKSP);
  assign buf_clear = key_fire && ((key_code == KEY_CLEAR) || (key_code == KEY_ENTER));
  assign full      = (digit_count == 3'(DIGITS));

  pin_digit_buffer #(.DIGITS(DIGITS)) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .push_i  (buf_push),
    .bksp_i  (buf_bksp),
    .clear_i (buf_clear),
    .digit_i (key_code),
    .pin_o   (buf_pin),
    .count_o (digit_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pin_out_q   <= '0;
      pin_valid_q <= 1'b0;
      unlock_q    <= 1'b0;
      fail_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      pin_out_q   <= '0;
      pin_valid_q <= 1'b0;
      unlock_q    <= 1'b0;
      fail_q      <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_valid && (key_code == KEY_ENTER)) begin
            if (full) begin
              pin_out_q   <= buf_pin;
              pin_valid_q <= 1'b1;
              state_q     <= S_SEND;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        S_SEND: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          // Deny takes priority so a glitching checker can never unlock.
          if (access_denied) begin
            fail_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_HOLD;
          end else if (access_granted) begin
            unlock_q <= 1'b1;
            state_q  <= S_IDLE;
          end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == CNT_W'(DENY_HOLD - 1)) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pin_out      = pin_out_q;
  assign pin_valid    = pin_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign unlock_pulse = unlock_q;
  assign fail_pulse   = fail_q;
  assign entry_error  = error_q;

endmodule

// File: tb/tb_pin_entry_keypad.sv
// tb/tb_pin_entry_keypad.sv - table-driven and directed self-checking bench for pin_entry_keypad
module tb_pin_entry_keypad;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        access_granted, access_denied;
  logic [15:0] pin_out;
  logic        pin_valid, busy, unlock_pulse, fail_pulse, entry_error;
  logic [2:0]  digit_count;

  int checks = 0;
  int failures = 0;

  pin_entry_keypad dut (
    .clk            (clk),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .access_granted (access_granted),
    .access_denied  (access_denied),
    .pin_out        (pin_out),
    .pin_valid      (pin_valid),
    .digit_count    (digit_count),
    .busy           (busy),
    .unlock_pulse   (unlock_pulse),
    .fail_pulse     (fail_pulse),
    .entry_error    (entry_error)
  );

  always #5 clk = ~clk;

  // Expected output bundle: {pin_valid, pin_out, digit_count, busy, unlock, fail, error}
  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        g;
    logic        d;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [23:0] e(input logic pv, input logic [15:0] pin, input logic [2:0] cnt,
                                    input logic bsy, input logic u, input logic f, input logic er);
    return {pv, pin, cnt, bsy, u, f, er};
  endfunction

  function automatic void add(input logic kv, input logic [3:0] kc, input logic g, input logic d,
                              input logic [23:0] exp);
    vec_t v;
    v.kv = kv; v.kc = kc; v.g = g; v.d = d; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [23:0] outs();
    return {pin_valid, pin_out, digit_count, busy, unlock_pulse, fail_pulse, entry_error};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    for (int i = 3; i >= 0; i--) press(pin[4*i +: 4]);
    press(4'hE);
  endtask

  initial begin
    int n;
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    access_granted = 1'b0; access_denied = 1'b0;
    step(); step();
    check("reset_state", {8'h0, outs()}, 32'h0);
    reset = 1'b0;

    // 8642 granted; a grant during SEND is ignored
    add(1, 4'h8, 0, 0, e(0, 16'h0, 1, 0, 0, 0, 0));
    add(1, 4'h6, 0, 0, e(0, 16'h0, 2, 0, 0, 0, 0));
    add(1, 4'h4, 0, 0, e(0, 16'h0, 3, 0, 0, 0, 0));
    add(1, 4'h2, 0, 0, e(0, 16'h0, 4, 0, 0, 0, 0));
    add(1, 4'hE, 0, 0, e(1, 16'h8642, 0, 1, 0, 0, 0));
    add(0, 4'h0, 1, 0, e(0, 16'h0, 0, 1, 0, 0, 0));
    add(0, 4'h0, 1, 0, e(0, 16'h0, 0, 0, 1, 0, 0));
    add(0, 4'h0, 0, 0, e(0, 16'h0, 0, 0, 0, 0, 0));
    // 8431 denied, 8-cycle hold with dropped keys
    add(1, 4'h8, 0, 0, e(0, 16'h0, 1, 0, 0, 0, 0));
    add(1, 4'h4, 0, 0, e(0, 16'h0, 2, 0, 0, 0, 0));
    add(1, 4'h3, 0, 0, e(0, 16'h0, 3, 0, 0, 0, 0));
    add(1, 4'h1, 0, 0, e(0, 16'h0, 4, 0, 0, 0, 0));
    add(1, 4'hE, 0, 0, e(1, 16'h8431, 0, 1, 0, 0, 0));
    add(0, 4'h0, 0, 0, e(0, 16'h0, 0, 1, 0, 0, 0));
    add(0, 4'h0, 0, 1, e(0, 16'h0, 0, 1, 0, 1, 0));
    add(1, 4'h1, 0, 0, e(0, 16'h0, 0, 1, 0, 0, 0));
    add(1, 4'h2, 0, 0, e(0, 16'h0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) add(0, 4'h0, 0, 0, e(0, 16'h0, 0, 1, 0, 0, 0));
    add(0, 4'h0, 0, 0, e(0, 16'h0, 0, 0, 0, 0, 0));
    add(1, 4'h5, 0, 0, e(0, 16'h0, 1, 0, 0, 0, 0));
    add(1, 4'hA, 0, 0, e(0, 16'h0, 0, 0, 0, 0, 0));
    // overflow digit, backspace, re-enter -> 3842
    add(1, 4'h3, 0, 0, e(0, 16'h0, 1, 0, 0, 0, 0));
    add(1, 4'h8, 0, 0, e(0, 16'h0, 2, 0, 0, 0, 0));
    add(1, 4'h4, 0, 0, e(0, 16'h0, 3, 0, 0, 0, 0));
    add(1, 4'h9, 0, 0, e(0, 16'h0, 4, 0, 0, 0, 0));
    add(1, 4'h7, 0, 0, e(0, 16'h0, 4, 0, 0, 0, 0));
    add(1, 4'hB, 0, 0, e(0, 16'h0, 3, 0, 0, 0, 0));
    add(1, 4'h2, 0, 0, e(0, 16'h0, 4, 0, 0, 0, 0));
    add(1, 4'hE, 0, 0, e(1, 16'h3842, 0, 1, 0, 0, 0));
    add(0, 4'h0, 0, 0, e(0, 16'h0, 0, 1, 0, 0, 0));
    add(0, 4'h0, 1, 0, e(0, 16'h0, 0, 0, 1, 0, 0));
    // short enter, backspace at zero, unknown codes
    add(1, 4'h1, 0, 0, e(0, 16'h0, 1, 0, 0, 0, 0));
    add(1, 4'h2, 0, 0, e(0, 16'h0, 2, 0, 0, 0, 0));
    add(1, 4'hE, 0, 0, e(0, 16'h0, 0, 0, 0, 0, 1));
    add(0, 4'h0, 0, 0, e(0, 16'h0, 0, 0, 0, 0, 0));
    add(1, 4'hB, 0, 0, e(0, 16'h0, 0, 0, 0, 0, 0));
    add(1, 4'hC, 0, 0, e(0, 16'h0, 0, 0, 0, 0, 0));
    add(1, 4'h7, 0, 0, e(0, 16'h0, 1, 0, 0, 0, 0));
    add(1, 4'hF, 0, 0, e(0, 16'h0, 1, 0, 0, 0, 0));
    add(1, 4'hA, 0, 0, e(0, 16'h0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      key_valid      = vecs[i].kv;
      key_code       = vecs[i].kc;
      access_granted = vecs[i].g;
      access_denied  = vecs[i].d;
      step();
      check($sformatf("vec%0d", i), {8'h0, outs()}, {8'h0, vecs[i].exp});
    end
    key_valid = 1'b0; key_code = 4'h0; access_granted = 1'b0; access_denied = 1'b0;

    // Response timeout: error 16 edges after entering WAIT_RESP
    enter_pin(16'h1234);
    check("timeout_pin", {15'h0, pin_valid, pin_out}, {15'h0, 1'b1, 16'h1234});
    step();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (entry_error) begin n = i; break; end
    end
    check("timeout_edges", n, 16);
    check("timeout_idle", {31'h0, busy}, 32'h0);

    // Simultaneous grant and deny: deny wins, then hold length
    enter_pin(16'h5555);
    step();
    access_granted = 1'b1; access_denied = 1'b1;
    step();
    access_granted = 1'b0; access_denied = 1'b0;
    check("both_resp", {30'h0, unlock_pulse, fail_pulse}, 32'h1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!busy) begin n = i; break; end
    end
    check("hold_len", n, 8);

    // Reset during WAIT_RESP drops the pending response
    enter_pin(16'h9999);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_wait", {27'h0, busy, digit_count, pin_valid}, 32'h0);
    access_granted = 1'b1;
    step();
    access_granted = 1'b0;
    check("post_reset_grant", {31'h0, unlock_pulse}, 32'h0);
    access_denied = 1'b1;
    step();
    access_denied = 1'b0;
    check("post_reset_deny", {30'h0, fail_pulse, busy}, 32'h0);

    // Reset discards a partial PIN
    press(4'h1); press(4'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_partial", {29'h0, digit_count}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
